circle_cmd_dispatch: RTL and testbench

Upstream command front-end for the circle engine. Pops 32-bit command words from a valid/ready stream (fed by the CPU-side command FIFO) and decodes them. Drives the circle engine's color/arguments/trigger handshake one circle at a time and holds the frame base register. Tracks engine completion through CE_ready, so commands stream back-to-back without software polling.

---
 rtl/circle_cmd_dispatch_pkg.sv | 41 ++++
 rtl/circle_cmd_dispatch_if.sv | 28 ++
 rtl/circle_cmd_dispatch_stats.sv | 43 ++++
 rtl/circle_cmd_dispatch.sv | 177 +++++++++++++++++
 tb/tb_circle_cmd_dispatch.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/circle_cmd_dispatch_pkg.sv
// Shared opcodes, FSM state encoding and argument field layout for circle_cmd_dispatch.
package circle_cmd_dispatch_pkg;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_SETBASE = 8'h01;
  localparam logic [7:0] OP_CIRCLE  = 8'h02;
  localparam logic [7:0] OP_END     = 8'hFF;

  localparam int X_LSB = 22;
  localparam int Y_LSB = 12;
  localparam int R_LSB = 0;
  localparam int X_W   = 10;
  localparam int Y_W   = 10;
  localparam int R_W   = 12;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_OPCODE     = 3'd1,
    ST_OPERAND    = 3'd2,
    ST_WAIT_IDLE  = 3'd3,
    ST_SEND_COLOR = 3'd4,
    ST_SEND_ARGS  = 3'd5,
    ST_WAIT_ACK   = 3'd6,
    ST_WAIT_DONE  = 3'd7
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [R_W-1:0] r;
  } circle_args_t;

  function automatic circle_args_t unpack_args(input logic [31:0] w);
    circle_args_t a;
    a.x = w[X_LSB +: X_W];
    a.y = w[Y_LSB +: Y_W];
    a.r = w[R_LSB +: R_W];
    return a;
  endfunction

endpackage

// File: rtl/circle_cmd_dispatch_if.sv
// Command stream plus circle-engine handshake; master = dispatcher, slave = command source / engine.
interface circle_cmd_dispatch_if;

  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;

  logic        CE_ready;
  logic [23:0] CE_color;
  logic        CE_color_valid;
  logic [31:0] CE_arguments;
  logic        CE_arguments_valid;
  logic        CE_trigger;
  logic [31:0] CE_frame_base;

  modport master (
    input  cmd_data, cmd_valid, CE_ready,
    output cmd_ready, CE_color, CE_color_valid, CE_arguments,
           CE_arguments_valid, CE_trigger, CE_frame_base
  );

  modport slave (
    output cmd_data, cmd_valid, CE_ready,
    input  cmd_ready, CE_color, CE_color_valid, CE_arguments,
           CE_arguments_valid, CE_trigger, CE_frame_base
  );

endinterface

// File: rtl/circle_cmd_dispatch_stats.sv
// Saturating circle / stall counters, present only when CMD_DISPATCH_STATS_EN is defined.
// Counters update one cycle after the qualifying FSM state; stat_clr beats a same-cycle increment.
`ifdef CMD_DISPATCH_STATS_EN
module cmd_dispatch_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stat_clr,
  input  logic        inc_circle,
  input  logic        inc_stall,
  output logic [31:0] stat_circles,
  output logic [31:0] stat_stall
);

  logic [31:0] circles_q, circles_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    circles_d = circles_q;
    stall_d   = stall_q;
    if (stat_clr) begin
      circles_d = '0;
      stall_d   = '0;
    end else begin
      if (inc_circle && (circles_q != '1)) circles_d = circles_q + 32'd1;
      if (inc_stall && (stall_q != '1))    stall_d   = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      circles_q <= '0;
      stall_q   <= '0;
    end else begin
      circles_q <= circles_d;
      stall_q   <= stall_d;
    end
  end

  assign stat_circles = circles_q;
  assign stat_stall   = stall_q;

endmodule
`endif

// File: rtl/circle_cmd_dispatch.sv
// Decodes command words and drives the circle engine one circle at a time; CMD_DISPATCH_STATS_EN adds stat counters.
// cmd_ready only in OPCODE/OPERAND (1 word/cycle in a command); color strobe after CE_ready, trigger the cycle after.
module circle_cmd_dispatch
  import circle_cmd_dispatch_pkg::*;
#(
  parameter logic [31:0] FRAME_BASE_RST = 32'h1040_0000,
  parameter int unsigned ACK_TIMEOUT    = 8,
  parameter int unsigned ACK_CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  circle_cmd_dispatch_if.master bus,
  input  logic                  err_clr,
`ifdef CMD_DISPATCH_STATS_EN
  input  logic                  stat_clr,
  output logic [31:0]           stat_circles,
  output logic [31:0]           stat_stall,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ACK_CNT_W-1:0] ACK_LAST = ACK_CNT_W'(ACK_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [7:0]            op_q, op_d;
  logic [23:0]           color_q, color_d;
  circle_args_t          args_q, args_d;
  logic [31:0]           base_q, base_d;
  logic [ACK_CNT_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  cmd_rdy;
  logic                  color_vld;
  logic                  args_vld;
  logic [7:0]            opcode;

  assign opcode = bus.cmd_data[31:24];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    color_d   = color_q;
    args_d    = args_q;
    base_d    = base_q;
    ack_cnt_d = ack_cnt_q;
    done_d    = 1'b0;
    err_d     = err_q & ~err_clr;
    cmd_rdy   = 1'b0;
    color_vld = 1'b0;
    args_vld  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) state_d = ST_OPCODE;
      end

      ST_OPCODE: begin
        cmd_rdy = 1'b1;
        if (bus.cmd_valid) begin
          op_d = opcode;
          case (opcode)
            OP_NOP:     state_d = ST_IDLE;
            OP_SETBASE: state_d = ST_OPERAND;
            OP_CIRCLE: begin
              color_d = bus.cmd_data[23:0];
              state_d = ST_OPERAND;
            end
            OP_END: begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
            default: begin
              // Set is applied after the clear so it wins a same-cycle err_clr.
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
      end

      ST_OPERAND: begin
        cmd_rdy = 1'b1;
        if (bus.cmd_valid) begin
          if (op_q == OP_SETBASE) begin
            base_d  = bus.cmd_data;
            state_d = ST_IDLE;
          end else begin
            args_d  = unpack_args(bus.cmd_data);
            state_d = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (bus.CE_ready) state_d = ST_SEND_COLOR;
      end

      ST_SEND_COLOR: begin
        color_vld = 1'b1;
        state_d   = ST_SEND_ARGS;
      end

      ST_SEND_ARGS: begin
        args_vld  = 1'b1;
        ack_cnt_d = '0;
        state_d   = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        // An engine that never drops CE_ready is treated as finished after ACK_TIMEOUT cycles.
        if (!bus.CE_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          state_d = ST_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_CNT_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        if (bus.CE_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      color_q   <= '0;
      args_q    <= '0;
      base_q    <= FRAME_BASE_RST;
      ack_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      color_q   <= color_d;
      args_q    <= args_d;
      base_q    <= base_d;
      ack_cnt_q <= ack_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.cmd_ready          = cmd_rdy;
  assign bus.CE_color           = color_q;
  assign bus.CE_color_valid     = color_vld;
  assign bus.CE_arguments       = args_q;
  assign bus.CE_arguments_valid = args_vld;
  assign bus.CE_trigger         = args_vld;
  assign bus.CE_frame_base      = base_q;

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;

`ifdef CMD_DISPATCH_STATS_EN
  cmd_dispatch_stats u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .stat_clr     (stat_clr),
    .inc_circle   (state_q == ST_SEND_ARGS),
    .inc_stall    ((state_q == ST_WAIT_IDLE) || (state_q == ST_WAIT_DONE)),
    .stat_circles (stat_circles),
    .stat_stall   (stat_stall)
  );
`endif

endmodule

// File: tb/tb_circle_cmd_dispatch.sv
// Directed table-driven bench for circle_cmd_dispatch with a small circle-engine responder.
module tb_circle_cmd_dispatch;

  logic clk = 1'b0;
  logic rst_n;
  logic err_clr;
  logic busy, done, err;
`ifdef CMD_DISPATCH_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_circles, stat_stall;
`endif

  circle_cmd_dispatch_if bus ();

  circle_cmd_dispatch #(
    .FRAME_BASE_RST (32'h1040_0000),
    .ACK_TIMEOUT    (8),
    .ACK_CNT_W      (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .err_clr      (err_clr),
`ifdef CMD_DISPATCH_STATS_EN
    .stat_clr     (stat_clr),
    .stat_circles (stat_circles),
    .stat_stall   (stat_stall),
`endif
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: after a trigger, drop CE_ready for ce_drop_len cycles (0 = never drop).
  int ce_drop_len = 0;
  initial begin
    bus.CE_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.CE_trigger && ce_drop_len > 0) begin
        @(posedge clk);
        #1 bus.CE_ready = 1'b0;
        repeat (ce_drop_len) @(posedge clk);
        #1 bus.CE_ready = 1'b1;
      end
    end
  end

  int          color_cnt = 0, trig_cnt = 0, av_cnt = 0, done_cnt = 0;
  logic [31:0] color_seen = '0, base_at_color = '0;
  int unsigned color_cyc = 0, trig_cyc = 0;
  logic [31:0] args_log[$];
  initial begin
    forever begin
      @(negedge clk);
      if (bus.CE_color_valid) begin
        color_cnt++;
        color_seen    = {8'h00, bus.CE_color};
        base_at_color = bus.CE_frame_base;
        color_cyc     = cyc;
      end
      if (bus.CE_trigger) begin
        trig_cnt++;
        trig_cyc = cyc;
        args_log.push_back(bus.CE_arguments);
      end
      if (bus.CE_arguments_valid) av_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit toggle);
    int k = 0;
    bit fired = 1'b0;
    bus.cmd_data  = w;
    bus.cmd_valid = 1'b1;
    while (!fired && k < 200) begin
      @(negedge clk);
      fired = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk);
      #1;
      k++;
      if (!fired && toggle) bus.cmd_valid = ~bus.cmd_valid;
    end
    bus.cmd_valid = 1'b0;
    if (toggle) step(1);
    if (!fired) begin
      n_vec++;
      n_err++;
      $display("FAIL send_%08h: no handshake in 200 cycles, expected cmd_ready", w);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: busy=1 after 300 cycles, expected 0");
    end
    step(1);
  endtask

  // Waits for the trigger strobe, then counts consecutive busy cycles after it.
  task automatic busy_after_trig(output int nb);
    int k = 0;
    nb = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.CE_trigger && k < 100);
    if (!bus.CE_trigger) begin
      n_vec++;
      n_err++;
      $display("FAIL trig_wait: CE_trigger=0 after 100 cycles, expected 1");
    end
    @(negedge clk);
    while (busy && nb < 200) begin
      nb++;
      @(negedge clk);
    end
    step(1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " cmd_ready"},   {31'd0, bus.cmd_ready},          32'd0);
    check({tag, " color_vld"},   {31'd0, bus.CE_color_valid},     32'd0);
    check({tag, " args_vld"},    {31'd0, bus.CE_arguments_valid}, 32'd0);
    check({tag, " trigger"},     {31'd0, bus.CE_trigger},         32'd0);
    check({tag, " color"},       {8'd0, bus.CE_color},            32'd0);
    check({tag, " args"},        bus.CE_arguments,                32'd0);
    check({tag, " frame_base"},  bus.CE_frame_base,               32'h1040_0000);
    check({tag, " busy"},        {31'd0, busy},                   32'd0);
    check({tag, " done"},        {31'd0, done},                   32'd0);
    check({tag, " err"},         {31'd0, err},                    32'd0);
  endtask

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    bit          has_op;
    logic [23:0] color;
    logic [31:0] args;
    logic [31:0] base;
    logic        err;
    int          done_inc;
    int          trig_inc;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] w0, input logic [31:0] w1, input bit has_op,
                              input logic [23:0] color, input logic [31:0] args,
                              input logic [31:0] base, input logic e, input int d, input int t);
    vec_t v;
    v.w0 = w0; v.w1 = w1; v.has_op = has_op; v.color = color; v.args = args;
    v.base = base; v.err = e; v.done_inc = d; v.trig_inc = t;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int d0, t0, nb, nd, idx;
    logic [23:0] tcol[3];
    logic [31:0] targ[3];

    tbl.push_back(mk(32'h0000_0000, 32'h0, 0, 24'h000000, 32'h0000_0000, 32'h1040_0000, 0, 0, 0));
    tbl.push_back(mk(32'h0200_FF00, 32'h0140_5005, 1, 24'h00FF00, 32'h0140_5005, 32'h1040_0000, 0, 0, 1));
    tbl.push_back(mk(32'h0100_0000, 32'h1080_0000, 1, 24'h00FF00, 32'h0140_5005, 32'h1080_0000, 0, 0, 0));
    tbl.push_back(mk(32'h0212_3456, 32'hFFFF_FFFF, 1, 24'h123456, 32'hFFFF_FFFF, 32'h1080_0000, 0, 0, 1));
    tbl.push_back(mk(32'h7A00_0000, 32'h0, 0, 24'h123456, 32'hFFFF_FFFF, 32'h1080_0000, 1, 0, 0));
    tbl.push_back(mk(32'hFF00_0000, 32'h0, 0, 24'h123456, 32'hFFFF_FFFF, 32'h1080_0000, 1, 1, 0));
    tbl.push_back(mk(32'h01AB_CDEF, 32'h0000_0000, 1, 24'h123456, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0));
    tbl.push_back(mk(32'h0300_0000, 32'h0, 0, 24'h123456, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0));
    tbl.push_back(mk(32'h00FF_FFFF, 32'h0, 0, 24'h123456, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0));

    rst_n         = 1'b0;
    err_clr       = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_valid = 1'b0;
`ifdef CMD_DISPATCH_STATS_EN
    stat_clr      = 1'b0;
`endif
    step(3);
    check_reset("reset");
    rst_n = 1'b1;
    step(2);

    for (int i = 0; i < tbl.size(); i++) begin
      d0 = done_cnt;
      t0 = trig_cnt;
      send_word(tbl[i].w0, 1'b0);
      if (tbl[i].has_op) send_word(tbl[i].w1, 1'b0);
      wait_idle();
      step(1);
      check($sformatf("v%0d color", i), {8'd0, bus.CE_color}, {8'd0, tbl[i].color});
      check($sformatf("v%0d args", i),  bus.CE_arguments, tbl[i].args);
      check($sformatf("v%0d base", i),  bus.CE_frame_base, tbl[i].base);
      check($sformatf("v%0d err", i),   {31'd0, err}, {31'd0, tbl[i].err});
      check($sformatf("v%0d done", i),  done_cnt - d0, tbl[i].done_inc);
      check($sformatf("v%0d trig", i),  trig_cnt - t0, tbl[i].trig_inc);
    end

    // Engine ignores the trigger: leave after ACK_TIMEOUT cycles, then accept the next circle.
    ce_drop_len = 0;
    send_word(32'h02AB_CDEF, 1'b0);
    send_word(32'h0010_0200, 1'b0);
    busy_after_trig(nb);
    check("timeout busy_cycles", nb, 8);
    t0 = trig_cnt;
    send_word(32'h0200_0001, 1'b0);
    send_word(32'h0000_0002, 1'b0);
    wait_idle();
    check("after_timeout trig", trig_cnt - t0, 1);
    check("after_timeout args", bus.CE_arguments, 32'h0000_0002);

    // Engine drops CE_ready for 20 cycles after the trigger.
    ce_drop_len = 20;
    send_word(32'h0200_FF00, 1'b0);
    send_word(32'h0140_5005, 1'b0);
    busy_after_trig(nb);
    check("drop busy_cycles", nb, 21);
    check("drop color_seen", color_seen, 32'h0000_FF00);
    check("drop args_seen", args_log[args_log.size()-1], 32'h0140_5005);
    check("drop trig_after_color", trig_cyc - color_cyc, 1);

    // New base must be visible by the color strobe of the following circle.
    ce_drop_len = 0;
    send_word(32'h0100_0000, 1'b0);
    send_word(32'h1080_0000, 1'b0);
    send_word(32'h0203_0405, 1'b0);
    send_word(32'h0000_1001, 1'b0);
    wait_idle();
    check("setbase base_at_color", base_at_color, 32'h1080_0000);
    check("setbase color_seen", color_seen, 32'h0003_0405);

    // err clear, set-beats-clear, and END pulse width.
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("err_clr clears", {31'd0, err}, 32'd0);
    err_clr = 1'b1;
    send_word(32'h5500_0000, 1'b0);
    check("err set_wins", {31'd0, err}, 32'd1);
    err_clr = 1'b0;
    step(1);
    check("err sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("err cleared", {31'd0, err}, 32'd0);
    send_word(32'hFF00_0000, 1'b0);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    step(1);
    check("done width", nd, 1);

    // Three circles with cmd_valid toggling every other cycle.
    ce_drop_len = 3;
    tcol[0] = 24'h111111; targ[0] = 32'h0040_2003;
    tcol[1] = 24'h222222; targ[1] = 32'h0080_4006;
    tcol[2] = 24'h333333; targ[2] = 32'h00C0_6009;
    idx = args_log.size();
    t0  = trig_cnt;
    for (int i = 0; i < 3; i++) begin
      send_word({8'h02, tcol[i]}, 1'b1);
      send_word(targ[i], 1'b1);
    end
    wait_idle();
    check("toggle trig_count", trig_cnt - t0, 3);
    for (int i = 0; i < 3; i++) begin
      if (idx + i < args_log.size())
        check($sformatf("toggle args%0d", i), args_log[idx+i], targ[i]);
      else
        check($sformatf("toggle args%0d", i), 32'hDEAD_DEAD, targ[i]);
    end

    // Reset asserted while waiting for the engine to finish.
    ce_drop_len = 20;
    send_word(32'h02AB_CDEF, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!bus.CE_trigger && k < 100);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset("midrst");
    step(2);
    rst_n = 1'b1;
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
